rr_bus_arbiter: RTL and testbench
=================================

// Module: rr_bus_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 8-bit datapath bus, built from MUX2X1 steering plus DFF2
//   state, between N requesters (controller, memory port, I/O, debug).
//   Issues a registered one-hot grant and holds it until the owner releases the bus.
//   Forces one dead (no-grant) cycle between owners so bus mux selects never overlap.
//   Owns the bus-select sequencing. The datapath muxes decode OWNER directly.
// PARAMETERS
//   N    4   number of requesters, N >= 2; OWNER width is $clog2(N)
//   TMO  15  grant watchdog limit in cycles, 1..255; used only when ARB_TIMEOUT_EN is defined
// PORTS
//   CLK      in   1           rising-edge clock, the only clock
//   CLR      in   1           reset, synchronous, active-high
//   REQ      in   N           request per requester; level, held high while the bus is wanted
//   DONE     in   N           release strobe per requester; only the current owner's bit is honoured
//   GNT      out  N           one-hot grant, registered; all-zero when no owner
//   BUSY     out  1           1 while any GNT bit is high
//   OWNER    out  $clog2(N)   index of the granted requester; holds its last value when idle
//   TMO_FLT  out  1           one-cycle pulse on a watchdog-forced release
// BEHAVIOUR
//   - Reset, sampled on the CLK edge with CLR=1:
//     state=IDLE, GNT=0, BUSY=0, OWNER=0, PTR=0, TMO_FLT=0, watchdog cnt=0.
//   - CLR mid-grant: GNT drops at that same edge. No dead cycle and no TMO_FLT are generated.
//   - PTR (internal): index with highest priority, range 0..N-1.
//   - State IDLE, at an edge with REQ != 0:
//     - winner = first set REQ bit scanning PTR, PTR+1, ..., N-1, 0, ... (mod N)
//     - GNT <= onehot(winner), OWNER <= winner, BUSY <= 1, state -> GRANT
//     - Latency from REQ sampled high in IDLE to GNT high is 1 edge.
//   - State IDLE with REQ == 0: outputs hold; GNT stays 0.
//   - State GRANT, at an edge with DONE[OWNER]=1 or REQ[OWNER]=0 (release):
//     - GNT <= 0, BUSY <= 0
//     - PTR <= (OWNER+1) mod N, wrapping N-1 -> 0
//     - state -> IDLE
//   - State GRANT with no release: GNT, OWNER and PTR hold.
//     DONE bits of non-owners and REQ changes of non-owners are ignored.
//   - Dead cycle: after a release the next GNT cannot appear before the following edge.
//     The minimum gap between two grants is therefore exactly one cycle with GNT=0.
//   - Simultaneous events:
//     - DONE[OWNER] together with a new REQ from the owner: release wins; the owner re-arbitrates.
//     - A lone requester is re-granted after the dead cycle (PTR advances, scan wraps to it).
//   - GNT is never multi-hot and never changes without passing through 0.
// CONFIGURATION
//   - Macro ARB_TIMEOUT_EN defined:
//     - 8-bit watchdog cnt clears on every grant and increments each GRANT cycle with no release.
//     - When cnt reaches TMO-1 with no release, the next edge forces a release:
//       GNT <= 0, PTR advances, TMO_FLT <= 1 for that one cycle.
//     - A normal release on the same edge as the watchdog limit has priority and gives TMO_FLT=0.
//   - Macro ARB_TIMEOUT_EN undefined:
//     - No counter logic is built and TMO_FLT is tied 0.
//     - A grant lasts until DONE[OWNER] or REQ[OWNER] drop, with no upper limit.
// TESTING
//   1. Reset: CLR=1 for 2 edges with REQ=4'b1111
//      -> GNT=0, BUSY=0, OWNER=0.
//      Then CLR=0 -> GNT=4'b0001 one edge later.
//   2. Round-robin: REQ=4'b1111 held, each owner pulses DONE on its 3rd grant cycle
//      -> GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
//   3. Lone requester and wrap: PTR=3, REQ=4'b0100 only
//      -> GNT=0100, OWNER=2; after its DONE -> 0000 then 0100 again (PTR=3 wraps through 0,1 to 2).
//   4. Ignored inputs: owner=1, drive DONE=4'b1101 and toggle REQ[3]
//      -> GNT stays 0010. Then drop REQ[1] -> GNT=0000 next edge, PTR=2.
//   5. Reset mid-grant: GNT=1000, CLR=1 for one edge
//      -> GNT=0, PTR=0, TMO_FLT=0. REQ=4'b1010 afterwards -> GNT=0010.
//   6. Watchdog (ARB_TIMEOUT_EN, TMO=15): REQ=4'b0011, owner 0 never releases
//      -> GNT=0000 with TMO_FLT=1 after 15 grant cycles, then GNT=0010.
//      Without the macro -> GNT=0001 held for 100+ cycles and TMO_FLT stays 0.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant held until release, with one dead cycle between owners.
// Optional grant watchdog is built only when the ARB_TIMEOUT_EN macro is defined.
module rr_bus_arbiter #(
    parameter int N   = 4,
    parameter int TMO = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 tmo_flt
);
    localparam int W = $clog2(N);

    if (N < 2 || TMO < 1 || TMO > 255) begin : g_bad_cfg
        $error("rr_bus_arbiter: need N >= 2 and TMO in 1..255");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   owner_q, owner_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           win_found;
    logic [W-1:0]   win_idx;
    logic [W-1:0]   scan_idx;
    logic           release_req;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    logic [7:0]     cnt_q, cnt_d;
    logic           flt_q, flt_d;
`endif

    // Modulo-N increment that also works when N is not a power of two.
    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
        return (v == W'(N - 1)) ? '0 : v + 1'b1;
    endfunction

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    assign release_req = done[owner_q] || !req[owner_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        flt_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = N'(1) << win_idx;
                    owner_d = win_idx;
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                // A genuine release outranks the watchdog on the same edge.
                if (release_req) begin
                    gnt_d   = '0;
                    ptr_d   = wrap_inc(owner_q);
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    gnt_d   = '0;
                    ptr_d   = wrap_inc(owner_q);
                    state_d = IDLE;
                    flt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            flt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            flt_q   <= flt_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign busy  = |gnt_q;
    assign owner = owner_q;

`ifdef ARB_TIMEOUT_EN
    assign tmo_flt = flt_q;
`else
    assign tmo_flt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed vector table, watchdog sequence, then random traffic against a reference model.
// Watchdog expectations follow the ARB_TIMEOUT_EN macro.
module tb_rr_bus_arbiter;
    localparam int N   = 4;
    localparam int TMO = 15;

    logic         clk;
    logic         clr;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         busy;
    logic [1:0]   owner;
    logic         tmo_flt;

    int passed = 0;
    int total  = 0;

    rr_bus_arbiter #(.N(N), .TMO(TMO)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .owner   (owner),
        .tmo_flt (tmo_flt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who holds the bus (-1 = nobody), priority pointer, last owner, watchdog age.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_age   = 0;
    bit m_flt   = 1'b0;

`ifdef ARB_TIMEOUT_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    task automatic model_edge(input logic c, input logic [N-1:0] r, input logic [N-1:0] d);
        m_flt = 1'b0;
        if (c) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = 0;
            m_age   = 0;
        end else if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (WDOG && m_age == TMO - 1) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_flt   = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_age   = 0;
                end
            end
        end
    endtask

    function automatic logic [N-1:0] model_gnt();
        return (m_owner >= 0) ? N'(1 << m_owner) : '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Apply inputs, take one rising edge, advance the model, sample 1 time unit later.
    task automatic step(input logic c, input logic [N-1:0] r, input logic [N-1:0] d);
        clr  = c;
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(c, r, d);
        #1;
    endtask

    typedef struct {
        logic         c;
        logic [N-1:0] r;
        logic [N-1:0] d;
        logic [N-1:0] g;
        logic [1:0]   o;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic [N-1:0] r, input logic [N-1:0] d,
                       input logic [N-1:0] g, input logic [1:0] o);
        vec_t v;
        v.c = c; v.r = r; v.d = d; v.g = g; v.o = o;
        vecs.push_back(v);
    endtask

    initial begin
        clr  = 1'b1;
        req  = '0;
        done = '0;
        #2;

        // Reset with all requesting, then first grant one edge after release of clr.
        add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0);
        // Round robin, DONE on third grant cycle, dead cycle between owners.
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0);
        add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0010, 4'b0000, 2'd1);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0100, 4'b0000, 2'd2);
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b1000, 4'b0000, 2'd3);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0);
        // Get owner 1, then non-owner DONE bits and REQ[3] toggles are ignored.
        add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b1101, 4'b0010, 2'd1);
        add(0, 4'b0111, 4'b1101, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(0, 4'b1101, 4'b0000, 4'b0000, 2'd1);
        add(0, 4'b1000, 4'b0000, 4'b1000, 2'd3);
        // Reset mid-grant, then pointer restarts from 0.
        add(1, 4'b1000, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b1010, 4'b0000, 4'b0010, 2'd1);
        add(0, 4'b1010, 4'b0010, 4'b0000, 2'd1);
        // Lone requester 2: pointer moves to 3 and the scan wraps back to 2.
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2'd2);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2'd2);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2);

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].g));
            check($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].o));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].g != 0));
            check($sformatf("vec%0d tmo_flt", i), 32'(tmo_flt), 32'd0);
        end

        // Watchdog: owner 0 never releases while requester 1 waits.
        step(1, 4'b0011, 4'b0000);
        step(0, 4'b0011, 4'b0000);
        check("wd grant", 32'(gnt), 32'b0001);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < TMO; k++) begin
            step(0, 4'b0011, 4'b0000);
            check($sformatf("wd hold%0d", k), 32'({gnt, tmo_flt}), 32'({4'b0001, 1'b0}));
        end
        step(0, 4'b0011, 4'b0000);
        check("wd force gnt", 32'(gnt), 32'b0000);
        check("wd force flt", 32'(tmo_flt), 32'd1);
        step(0, 4'b0011, 4'b0000);
        check("wd next gnt", 32'(gnt), 32'b0010);
        check("wd next flt", 32'(tmo_flt), 32'd0);
`else
        for (int k = 1; k <= 120; k++) begin
            step(0, 4'b0011, 4'b0000);
            if (k % 20 == 0)
                check($sformatf("nowd hold%0d", k), 32'({gnt, tmo_flt}), 32'({4'b0001, 1'b0}));
        end
`endif

        // Random traffic against the model.
        step(1, 4'b0000, 4'b0000);
        begin
            logic [N-1:0] r;
            logic [N-1:0] d;
            logic [N-1:0] prev_g;
            r = '0;
            prev_g = gnt;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) r = N'($urandom);
                d = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
                step($urandom_range(0, 99) == 0, r, d);
                check("rnd gnt", 32'(gnt), 32'(model_gnt()));
                check("rnd owner", 32'(owner), 32'(m_last));
                check("rnd busy", 32'(busy), 32'(m_owner >= 0));
                check("rnd tmo_flt", 32'(tmo_flt), 32'(m_flt));
                check("rnd onehot", 32'($countones(gnt) <= 1), 32'd1);
                check("rnd via zero", 32'(prev_g == 0 || gnt == 0 || gnt == prev_g), 32'd1);
                prev_g = gnt;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
